avg_filter: RTL and testbench

- Streaming moving-average filter: outputs the mean of the most recent FIFO_DEPTH accepted input samples.
- The mean is computed as the window sum right-shifted by log2(FIFO_DEPTH).
- Sits inline on a valid-qualified data stream, with no backpressure.
- Adds a small debug capture/readback port for bring-up.

---
 rtl/avg_filter.sv | 89 ++++++++
 tb/tb_avg_filter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/avg_filter.sv
// Streaming moving-average filter: mean of the last FIFO_DEPTH accepted samples,
// registered one cycle after the qualifying sample, plus a small debug capture port.
module avg_filter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  W,
  input  logic                  R,
  output logic [DATA_WIDTH-1:0] debug_data_o,
  output logic                  debug_valid_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int SUM_W = DATA_WIDTH + AW;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [SUM_W-1:0]      sum_reg;
  logic [SUM_W-1:0]      sum_next;
  logic [SUM_W-1:0]      avg_next;
  logic [DATA_WIDTH-1:0] oldest;
  logic                  window_full;
  logic                  emit_next;
  logic [DATA_WIDTH-1:0] dbg_cap_reg;

  // The oldest entry is read combinationally so it can leave the sum on the
  // same edge its slot is overwritten.
  always_comb begin
    oldest      = mem[wr_ptr_reg];
    window_full = (cnt_reg == CNT_W'(FIFO_DEPTH));
    sum_next    = sum_reg + SUM_W'(data_i);
    if (window_full) begin
      sum_next = sum_reg + SUM_W'(data_i) - SUM_W'(oldest);
    end
    avg_next  = sum_next >> AW;
    emit_next = valid_i && (cnt_reg >= CNT_W'(FIFO_DEPTH - 1));
  end

  // Sample storage carries no reset; stale entries are masked by cnt_reg.
  always_ff @(posedge clk) begin
    if (rst_n && valid_i) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      sum_reg       <= '0;
      data_o        <= '0;
      valid_o       <= 1'b0;
      dbg_cap_reg   <= '0;
      debug_data_o  <= '0;
      debug_valid_o <= 1'b0;
    end else begin
      valid_o       <= 1'b0;
      debug_valid_o <= 1'b0;
      if (valid_i) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        sum_reg    <= sum_next;
        if (!window_full) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      if (emit_next) begin
        data_o  <= avg_next[DATA_WIDTH-1:0];
        valid_o <= 1'b1;
      end
      // Readback uses the pre-edge capture when a read and a capture coincide.
      if (R) begin
        debug_valid_o <= 1'b1;
        debug_data_o  <= dbg_cap_reg;
      end
      if (W && valid_i) begin
        dbg_cap_reg <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_avg_filter.sv
// Self-checking bench for avg_filter: directed scenarios plus randomized traffic,
// compared against a queue-based window-average reference model.
module tb_avg_filter;

  localparam int DW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          W;
  logic          R;
  logic [DW-1:0] debug_data_o;
  logic          debug_valid_o;

  avg_filter #(.DATA_WIDTH(DW), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_i(data_i),
    .valid_i(valid_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .W(W),
    .R(R),
    .debug_data_o(debug_data_o),
    .debug_valid_o(debug_valid_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] hist[$];
  int            n_acc;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] dbg_cap;
  int            pulses;
  int            n_checks;
  int            n_errors;

  function automatic logic [DW-1:0] window_avg();
    longint unsigned s = 0;
    foreach (hist[i]) s += longint'(hist[i]);
    return DW'(s / D);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit w, input bit r);
    logic [DW-1:0] cap_before;
    valid_i = v; data_i = d; W = w; R = r;
    @(posedge clk);
    cap_before = dbg_cap;
    exp_valid = 1'b0;
    if (v) begin
      hist.push_back(d);
      if (hist.size() > D) void'(hist.pop_front());
      n_acc++;
      if (n_acc >= D) begin
        exp_valid = 1'b1;
        exp_data  = window_avg();
      end
      if (w) dbg_cap = d;
    end
    #1;
    chk("valid_o", {31'b0, valid_o}, {31'b0, exp_valid});
    chk("data_o", data_o, exp_data);
    chk("debug_valid_o", {31'b0, debug_valid_o}, {31'b0, r});
    if (r) chk("debug_data_o", debug_data_o, cap_before);
    if (valid_o) pulses++;
    $display("step v=%0b d=%h w=%0b r=%0b -> valid_o=%0b data_o=%h dbg_v=%0b dbg_d=%h",
             v, d, w, r, valid_o, data_o, debug_valid_o, debug_data_o);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b1; data_i = $urandom; W = 1'b1; R = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
      chk("rst_data_o", data_o, 32'd0);
      chk("rst_debug_valid_o", {31'b0, debug_valid_o}, 32'd0);
      $display("reset cycle %0d -> valid_o=%0b data_o=%h", i, valid_o, data_o);
    end
    hist.delete();
    n_acc = 0; exp_data = '0; dbg_cap = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; pulses = 0;
    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; W = 1'b0; R = 1'b0;
    do_reset(3);

    // 15 samples 1..15: outputs after samples 8..15
    pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 8) chk("first_avg", data_o, 32'd4);
      if (i == 9) chk("second_avg", data_o, 32'd5);
    end
    chk("pulses_15", DW'(pulses), 32'd8);

    // Idle gap, then window spanning the gap
    pulses = 0;
    for (int i = 0; i < 10; i++) step(1'b0, $urandom, 1'b0, 1'b0);
    chk("pulses_gap", DW'(pulses), 32'd0);
    for (int i = 16; i <= 20; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    chk("gap_window_avg", data_o, 32'd16);
    chk("pulses_after_gap", DW'(pulses), 32'd5);

    // Mid-stream reset then fresh fill
    do_reset(10);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      if (i == 6) chk("no_early_pulse", DW'(pulses), 32'd0);
    end
    chk("pulses_after_reset", DW'(pulses), 32'd13);

    // Saturated inputs then drain to zero
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("all_max", data_o, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) step(1'b1, 32'd0, 1'b0, 1'b0);
    chk("drained", data_o, 32'd0);

    // Debug capture and readback
    for (int i = 0; i < 20; i++) step(1'b1, (i == 19) ? 32'd7 : $urandom, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("debug_readback", debug_data_o, 32'd7);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    // Coincident capture and read returns the earlier value
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
    chk("debug_coincident", debug_data_o, 32'd7);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("debug_new_capture", debug_data_o, 32'h1234_5678);

    // Fewer than a window of samples never produces output
    do_reset(2);
    pulses = 0;
    for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, $urandom, 1'b0, 1'b0);
    chk("pulses_partial", DW'(pulses), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(2);
      else step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
